mem_access_arbiter: RTL and testbench

//  Shares one memory instance (separate rd/wr ports, 1-cycle registered read) among
//  NUM_REQ requesters using valid/ready requests. Two independent round-robin arbiters:
//  one for reads, one for writes. One read and one write can be granted per cycle.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/mem_access_arbiter.sv | 89 ++++++++
 tb/tb_mem_access_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared defaults for the memory subsystem: word width, depth, requester count
// and the clog2 helper used for address widths by both arbiter and memory.
package mem_pkg;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_MAX_ADDR   = 8;
  localparam int DEF_NUM_REQ    = 3;

  // Ceiling log2, usable in parameter expressions; a value of 1 yields 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting bit at or above the
// pointer (wrapping), and moves the pointer one past the winner.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int N = DEF_NUM_REQ
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_idx;
  logic             found;

  // Scan upward from the pointer; no grants at all while held in reset.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
    if (!reset_n) begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
    end
  end

  // Pointer moves past the winner so it has lowest priority next time.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one memory (separate read/write ports, registered read) among
// NUM_REQ valid/ready requesters with independent read and write round-robin
// arbiters, returning read data with a one-hot requester tag.
module mem_access_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_ADDR   = DEF_MAX_ADDR,
  parameter int ADDRSIZE   = clog2(MAX_ADDR),
  parameter int NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDRSIZE-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           mem_reset,
  output logic                           mem_rd_en,
  output logic [ADDRSIZE-1:0]            mem_rd_addr,
  output logic                           mem_wr_en,
  output logic [ADDRSIZE-1:0]            mem_wr_addr,
  output logic [DATA_WIDTH-1:0]          mem_wr_data,
  input  logic [DATA_WIDTH-1:0]          mem_rd_data
);

  logic [NUM_REQ-1:0] rd_cand_p0;
  logic [NUM_REQ-1:0] wr_cand_p0;
  logic [NUM_REQ-1:0] rd_grant_p0;
  logic [NUM_REQ-1:0] wr_grant_p0;
  logic [NUM_REQ-1:0] rsp_vld_p1;

  // Stage p0: request classification and arbitration (combinational)
  assign rd_cand_p0 = req_valid & ~req_we;
  assign wr_cand_p0 = req_valid &  req_we;

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (rd_cand_p0),
    .grant   (rd_grant_p0)
  );

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (wr_cand_p0),
    .grant   (wr_grant_p0)
  );

  assign req_ready = rd_grant_p0 | wr_grant_p0;
  assign mem_rd_en = |rd_grant_p0;
  assign mem_wr_en = |wr_grant_p0;
  assign mem_reset = ~reset_n;

  // Grants are one-hot, so an OR of the selected slices forms the mux and
  // naturally gives zero when nothing is granted.
  always_comb begin
    mem_rd_addr = '0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_grant_p0[i]) begin
        mem_rd_addr = mem_rd_addr | req_addr[i*ADDRSIZE +: ADDRSIZE];
      end
      if (wr_grant_p0[i]) begin
        mem_wr_addr = mem_wr_addr | req_addr[i*ADDRSIZE +: ADDRSIZE];
        mem_wr_data = mem_wr_data | req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Stage p1: response tag tracks the memory's one-cycle read latency
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rsp_vld_p1 <= '0;
    end else begin
      rsp_vld_p1 <= rd_grant_p0;
    end
  end

  assign rsp_valid = rsp_vld_p1;
  // The memory's registered output holds between reads, so data is passed through.
  assign rsp_data  = mem_rd_data;

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

  localparam int DW = 3;
  localparam int MA = 4;
  localparam int AW = 2;
  localparam int NR = 3;

  logic              clk;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_we;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              mem_reset;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  logic              mem_wr_en;
  logic [AW-1:0]     mem_wr_addr;
  logic [DW-1:0]     mem_wr_data;
  logic [DW-1:0]     mem_rd_data;

  logic [DW-1:0]     mem [MA];

  int n_checks;
  int n_errors;

  mem_access_arbiter #(
    .DATA_WIDTH (DW),
    .MAX_ADDR   (MA),
    .ADDRSIZE   (AW),
    .NUM_REQ    (NR)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .mem_reset   (mem_reset),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached memory: synchronous clear, registered read of the old word, write after the edge.
  always @(posedge clk) begin
    if (mem_reset) begin
      for (int i = 0; i < MA; i++) mem[i] <= '0;
      mem_rd_data <= '0;
    end else begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input int addr, input int wdata);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = AW'(addr);
    req_wdata[i*DW +: DW] = DW'(wdata);
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NR-1:0] order [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    mem_rd_data = '0;
    clear_req();
    reset_n = 1'b0;

    // 1. Reset: a pending request must not be granted
    set_req(0, 1'b0, 1, 0);
    #1;
    check("rst_ready", 32'(req_ready), 32'b000);
    check("rst_mem_reset", 32'(mem_reset), 32'd1);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    tick();
    tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'b000);
    check("rst_mem_clear", {mem[0], mem[1], mem[2], mem[3]}, 32'd0);
    clear_req();
    reset_n = 1'b1;
    #1;
    check("rel_mem_reset", 32'(mem_reset), 32'd0);

    // 2. Write then read back
    set_req(0, 1'b1, 3, 5);
    #1;
    check("wr_ready", 32'(req_ready), 32'b001);
    check("wr_en", 32'(mem_wr_en), 32'd1);
    check("wr_addr", 32'(mem_wr_addr), 32'd3);
    check("wr_data", 32'(mem_wr_data), 32'd5);
    check("wr_rd_en_idle", 32'(mem_rd_en), 32'd0);
    tick();
    clear_req();
    check("wr_mem3", 32'(mem[3]), 32'd5);
    set_req(0, 1'b0, 3, 0);
    #1;
    check("rd_ready", 32'(req_ready), 32'b001);
    check("rd_addr", 32'(mem_rd_addr), 32'd3);
    check("rd_wr_addr_idle", 32'(mem_wr_addr), 32'd0);
    tick();
    clear_req();
    check("rd_rsp_valid", 32'(rsp_valid), 32'b001);
    check("rd_rsp_data", 32'(rsp_data), 32'd5);

    // 3. Preload mem[2]=4 via req1 write, then req2 read brings rd_ptr back to 0
    set_req(1, 1'b1, 2, 4);
    #1;
    check("pre_wr_ready", 32'(req_ready), 32'b010);
    tick();
    clear_req();
    set_req(2, 1'b0, 2, 0);
    #1;
    check("pre_rd_ready", 32'(req_ready), 32'b100);
    tick();
    clear_req();
    check("pre_rd_data", 32'(rsp_data), 32'd4);
    check("rsp_idle", 32'(rsp_valid), 32'b100);
    #1;
    // All three read addr2 with valid held
    order[0] = 3'b001;
    order[1] = 3'b010;
    order[2] = 3'b100;
    order[3] = 3'b001;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 2, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(order[k]));
      tick();
      check($sformatf("rr_rsp%0d", k), 32'(rsp_valid), 32'(order[k]));
      check($sformatf("rr_data%0d", k), 32'(rsp_data), 32'd4);
    end
    clear_req();
    tick();
    check("rsp_clear", 32'(rsp_valid), 32'b000);
    check("rsp_data_hold", 32'(rsp_data), 32'd4);

    // 4. mem[1]=3 (wr_ptr=2 so req2 wins), then same-address write and read
    set_req(2, 1'b1, 1, 3);
    #1;
    check("m1_wr_ready", 32'(req_ready), 32'b100);
    tick();
    clear_req();
    set_req(0, 1'b1, 1, 7);
    set_req(1, 1'b0, 1, 0);
    #1;
    check("same_ready", 32'(req_ready), 32'b011);
    tick();
    clear_req();
    check("same_rsp_valid", 32'(rsp_valid), 32'b010);
    check("same_rsp_old", 32'(rsp_data), 32'd3);
    check("same_mem1_new", 32'(mem[1]), 32'd7);
    set_req(2, 1'b0, 1, 0);
    #1;
    tick();
    clear_req();
    check("later_rsp_valid", 32'(rsp_valid), 32'b100);
    check("later_rsp_data", 32'(rsp_data), 32'd7);

    // 5. Move rd_ptr to 1, then reset right after a read is accepted
    set_req(0, 1'b0, 0, 0);
    #1;
    tick();
    clear_req();
    set_req(2, 1'b0, 1, 0);
    #1;
    check("rstmid_ready", 32'(req_ready), 32'b100);
    #1;
    reset_n = 1'b0;
    tick();
    clear_req();
    check("rstmid_rsp", 32'(rsp_valid), 32'b000);
    check("rstmid_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'd0);
    tick();
    reset_n = 1'b1;
    set_req(0, 1'b0, 0, 0);
    set_req(2, 1'b0, 0, 0);
    #1;
    check("post_rst_lowest", 32'(req_ready), 32'b001);
    tick();
    clear_req();

    // 6. req1 writes continuously; req0 writes once; concurrent read by req2
    set_req(1, 1'b1, 0, 1);
    #1;
    check("hog_first", 32'(req_ready), 32'b010);
    tick();
    set_req(0, 1'b1, 2, 6);
    set_req(2, 1'b0, 0, 0);
    #1;
    check("fair_ready", 32'(req_ready), 32'b101);
    check("fair_wr_addr", 32'(mem_wr_addr), 32'd2);
    check("fair_rd_en", 32'(mem_rd_en), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    req_valid[2] = 1'b0;
    check("fair_mem2", 32'(mem[2]), 32'd6);
    check("fair_rsp_valid", 32'(rsp_valid), 32'b100);
    check("fair_rsp_data", 32'(rsp_data), 32'd1);
    #1;
    check("hog_again", 32'(req_ready), 32'b010);
    tick();
    clear_req();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
